// File: rtl/conv_mac_sequencer_pkg.sv
// Shared types and widths for the convolution MAC sequencer.
// Index-width values (i, k) carry one extra bit so i can reach sizeX+sizeY-2.
package conv_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 5;
  localparam int IDX_WIDTH  = ADDR_WIDTH + 1;
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [IDX_WIDTH-1:0]  idx_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    READ,
    WAIT,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/conv_mac_sequencer_if.sv
// Configuration inputs and memory/MAC command outputs of the sequencer.
// The sequencer takes the master side; the surrounding system takes the slave side.
interface conv_mac_sequencer_if;
  import conv_pkg::*;

  logic                 start_i;
  addr_t                sizeX_i;
  addr_t                sizeY_i;
  addr_t                memX_addr_o;
  addr_t                memY_addr_o;
  logic [IDX_WIDTH-1:0] memZ_addr_o;
  logic                 memZ_we_o;
  logic                 mac_en_o;
  logic                 mac_clr_o;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    input  start_i, sizeX_i, sizeY_i,
    output memX_addr_o, memY_addr_o, memZ_addr_o, memZ_we_o,
    output mac_en_o, mac_clr_o, busy_o, done_o
  );

  modport slave (
    output start_i, sizeX_i, sizeY_i,
    input  memX_addr_o, memY_addr_o, memZ_addr_o, memZ_we_o,
    input  mac_en_o, mac_clr_o, busy_o, done_o
  );

endinterface

// File: rtl/conv_mac_sequencer_kbounds.sv
// Product range for output index i: kmin = max(0, i-(sizeY-1)), kmax = min(i, sizeX-1).
// All sums stay below 2^IDX_WIDTH because sizes are at most 2^ADDR_WIDTH-1.
module conv_kbounds
  import conv_pkg::*;
(
  input  idx_t  i_i,
  input  addr_t sizeX_i,
  input  addr_t sizeY_i,
  output idx_t  kmin_o,
  output idx_t  kmax_o,
  output logic  last_idx_o
);

  idx_t sx;
  idx_t sy;
  idx_t i_plus1;

  assign sx      = {1'b0, sizeX_i};
  assign sy      = {1'b0, sizeY_i};
  assign i_plus1 = i_i + idx_t'(1);

  always_comb begin
    kmin_o     = (i_plus1 > sy) ? (i_plus1 - sy) : '0;
    kmax_o     = (i_plus1 < sx) ? i_i : (sx - idx_t'(1));
    last_idx_o = ((i_plus1 + idx_t'(1)) == (sx + sy));
  end

endmodule

// File: rtl/conv_mac_sequencer.sv
// Walks every output index of Z = X * Y, issuing X/Y reads, MAC enable/clear
// and one Z write per index. Bounds for the next index are loaded alongside i.
module conv_mac_sequencer
  import conv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  conv_mac_sequencer_if.master bus
);

  state_t state_q, state_d;
  idx_t   i_q, i_d;
  idx_t   k_q, k_d;
  idx_t   kmax_q, kmax_d;
  logic   last_q, last_d;
  addr_t  szx_q, szx_d;
  addr_t  szy_q, szy_d;
  logic   en_q;
  logic   load_bounds;

  idx_t   kb_kmin;
  idx_t   kb_kmax;
  logic   kb_last;

  // Bounds are evaluated for the index about to be entered, so READ starts at kmin.
  conv_kbounds u_kbounds (
    .i_i        (i_d),
    .sizeX_i    (szx_d),
    .sizeY_i    (szy_d),
    .kmin_o     (kb_kmin),
    .kmax_o     (kb_kmax),
    .last_idx_o (kb_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      k_q     <= '0;
      kmax_q  <= '0;
      last_q  <= 1'b0;
      szx_q   <= '0;
      szy_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      k_q     <= k_d;
      kmax_q  <= kmax_d;
      last_q  <= last_d;
      szx_q   <= szx_d;
      szy_q   <= szy_d;
      en_q    <= (state_q == READ);
    end
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    szx_d       = szx_q;
    szy_d       = szy_q;
    load_bounds = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          szx_d = bus.sizeX_i;
          szy_d = bus.sizeY_i;
          i_d   = '0;
          if ((bus.sizeX_i == '0) || (bus.sizeY_i == '0)) begin
            state_d = DONE;
          end else begin
            state_d     = INIT;
            load_bounds = 1'b1;
          end
        end
      end
      INIT:  state_d = READ;
      READ: begin
        if (k_q == kmax_q) state_d = WAIT;
      end
      WAIT:  state_d = WRITE;
      WRITE: begin
        if (last_q) begin
          state_d = DONE;
        end else begin
          i_d         = i_q + idx_t'(1);
          load_bounds = 1'b1;
          state_d     = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    k_d    = k_q;
    kmax_d = kmax_q;
    last_d = last_q;
    if (load_bounds) begin
      k_d    = kb_kmin;
      kmax_d = kb_kmax;
      last_d = kb_last;
    end else if (state_q == READ) begin
      k_d = k_q + idx_t'(1);
    end
  end

  // Y address i-k always fits ADDR_WIDTH, so the low bits of the difference suffice.
  assign bus.memX_addr_o = (state_q == READ) ? k_q[ADDR_WIDTH-1:0] : '0;
  assign bus.memY_addr_o = (state_q == READ) ?
                           (i_q[ADDR_WIDTH-1:0] - k_q[ADDR_WIDTH-1:0]) : '0;
  assign bus.memZ_addr_o = (state_q == WRITE) ? i_q : '0;
  assign bus.memZ_we_o   = (state_q == WRITE);
  assign bus.mac_en_o    = en_q;
  assign bus.mac_clr_o   = (state_q == INIT) || (state_q == WRITE);
  assign bus.busy_o      = (state_q == INIT) || (state_q == READ) ||
                           (state_q == WAIT) || (state_q == WRITE);
  assign bus.done_o      = (state_q == DONE);

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench: sync-read X/Y memories, a MAC model and a Z memory around the
// sequencer; expected Z contents and cycle counts are hand-computed constants.
module tb_conv_mac_sequencer;
  import conv_pkg::*;

  logic clk;
  logic rst;

  conv_mac_sequencer_if bus ();

  conv_mac_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_WIDTH-1:0] xmem [0:31];
  logic [DATA_WIDTH-1:0] ymem [0:31];
  logic [ACC_WIDTH-1:0]  zmem [0:63];
  logic [DATA_WIDTH-1:0] x_rd, y_rd;
  logic [ACC_WIDTH-1:0]  acc;

  always @(posedge clk) begin
    x_rd <= xmem[bus.memX_addr_o];
    y_rd <= ymem[bus.memY_addr_o];
    if (bus.mac_clr_o) acc <= '0;
    else if (bus.mac_en_o) acc <= acc + ACC_WIDTH'(x_rd) * ACC_WIDTH'(y_rd);
    if (bus.memZ_we_o) zmem[bus.memZ_addr_o] <= acc;
  end

  int we_cnt = 0, en_cnt = 0, busy_cnt = 0, both_cnt = 0, xy_over_cnt = 0, z_over_cnt = 0;

  always @(negedge clk) begin
    if (bus.memZ_we_o) we_cnt <= we_cnt + 1;
    if (bus.mac_en_o) en_cnt <= en_cnt + 1;
    if (bus.busy_o) busy_cnt <= busy_cnt + 1;
    if (bus.mac_en_o && bus.mac_clr_o) both_cnt <= both_cnt + 1;
    if (bus.memX_addr_o > 30 || bus.memY_addr_o > 30) xy_over_cnt <= xy_over_cnt + 1;
    if (bus.memZ_addr_o > 60) z_over_cnt <= z_over_cnt + 1;
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] all_outputs();
    return {bus.memX_addr_o, bus.memY_addr_o, bus.memZ_addr_o, bus.memZ_we_o,
            bus.mac_en_o, bus.mac_clr_o, bus.busy_o, bus.done_o};
  endfunction

  // Starts a run; optionally pulses start again (with other sizes) at cycle inj_at.
  task automatic run(input string tag, input int sx, input int sy, input int inj_at,
                     output int cyc);
    @(negedge clk);
    bus.sizeX_i = addr_t'(sx);
    bus.sizeY_i = addr_t'(sy);
    bus.start_i = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    bus.start_i = 1'b0;
    while (bus.done_o !== 1'b1 && cyc < 4000) begin
      if (cyc == inj_at) begin
        bus.start_i = 1'b1;
        bus.sizeX_i = addr_t'(1);
        bus.sizeY_i = addr_t'(1);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    check({tag, "_done_seen"}, bus.done_o, 1);
    @(negedge clk);
    check({tag, "_done_pulse_len"}, bus.done_o, 0);
  endtask

  initial begin
    int cyc;
    int w0, e0, b0, c0;
    int n;
    logic [ACC_WIDTH-1:0] exp_z;

    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.sizeX_i = '0;
    bus.sizeY_i = '0;
    for (int j = 0; j < 32; j++) begin
      xmem[j] = '0;
      ymem[j] = '0;
    end
    #1;
    check("reset_outputs", all_outputs(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic run: X=[1,2,3], Y=[4,5]
    xmem[0] = 1; xmem[1] = 2; xmem[2] = 3;
    ymem[0] = 4; ymem[1] = 5;
    w0 = we_cnt; c0 = both_cnt;
    run("basic", 3, 2, -1, cyc);
    check("basic_cycles", cyc, 16);
    check("basic_writes", we_cnt - w0, 4);
    check("basic_z0", zmem[0], 4);
    check("basic_z1", zmem[1], 13);
    check("basic_z2", zmem[2], 22);
    check("basic_z3", zmem[3], 15);
    check("basic_en_clr", both_cnt - c0, 0);

    // Minimal run: X=[7], Y=[9]
    xmem[0] = 7; ymem[0] = 9;
    w0 = we_cnt;
    run("minimal", 1, 1, -1, cyc);
    check("minimal_cycles", cyc, 5);
    check("minimal_writes", we_cnt - w0, 1);
    check("minimal_z0", zmem[0], 63);

    // Zero size: no activity besides done
    w0 = we_cnt; e0 = en_cnt; b0 = busy_cnt;
    run("zero", 0, 5, -1, cyc);
    check("zero_cycles", cyc, 1);
    check("zero_writes", we_cnt - w0, 0);
    check("zero_en", en_cnt - e0, 0);
    check("zero_busy", busy_cnt - b0, 0);

    // Start while busy: X=[3,1,2], Y=[2,1] with a stray start during READ
    xmem[0] = 3; xmem[1] = 1; xmem[2] = 2;
    ymem[0] = 2; ymem[1] = 1;
    w0 = we_cnt;
    run("busy_start", 3, 2, 5, cyc);
    check("busy_start_cycles", cyc, 16);
    check("busy_start_writes", we_cnt - w0, 4);
    check("busy_start_z0", zmem[0], 6);
    check("busy_start_z1", zmem[1], 5);
    check("busy_start_z2", zmem[2], 5);
    check("busy_start_z3", zmem[3], 2);

    // Maximum size, all samples 255
    for (int j = 0; j < 31; j++) begin
      xmem[j] = 8'd255;
      ymem[j] = 8'd255;
    end
    w0 = we_cnt; c0 = both_cnt;
    run("max", 31, 31, -1, cyc);
    check("max_cycles", cyc, 1085);
    check("max_writes", we_cnt - w0, 61);
    check("max_en_clr", both_cnt - c0, 0);
    check("max_xy_range", xy_over_cnt, 0);
    check("max_z_range", z_over_cnt, 0);
    for (int j = 0; j < 61; j++) begin
      n = (j < 31) ? j + 1 : 61 - j;
      exp_z = ACC_WIDTH'((n * 65025) % 65536);
      check($sformatf("max_z%0d", j), zmem[j], exp_z);
    end

    // Reset during READ of i=2: X=[2,1,3], Y=[1,1]
    xmem[0] = 2; xmem[1] = 1; xmem[2] = 3;
    ymem[0] = 1; ymem[1] = 1;
    w0 = we_cnt;
    @(negedge clk);
    bus.sizeX_i = addr_t'(3);
    bus.sizeY_i = addr_t'(2);
    bus.start_i = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    bus.start_i = 1'b0;
    while (cyc < 9) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("abort_x_addr", bus.memX_addr_o, 1);
    check("abort_y_addr", bus.memY_addr_o, 1);
    check("abort_busy", bus.busy_o, 1);
    rst = 1'b1;
    #1;
    check("abort_outputs", all_outputs(), 0);
    @(negedge clk);
    check("abort_outputs_held", all_outputs(), 0);
    rst = 1'b0;
    check("abort_writes", we_cnt - w0, 2);
    check("abort_z2_untouched", zmem[2], 64003);

    w0 = we_cnt;
    run("after_reset", 3, 2, -1, cyc);
    check("after_reset_cycles", cyc, 16);
    check("after_reset_writes", we_cnt - w0, 4);
    check("after_reset_z0", zmem[0], 2);
    check("after_reset_z1", zmem[1], 3);
    check("after_reset_z2", zmem[2], 4);
    check("after_reset_z3", zmem[3], 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/conv_mac_sequencer.md
# conv_mac_sequencer

Control sequencer driving the convolution multiply-accumulate datapath. On a start pulse it walks every output index of Z = X ∗ Y. For each index it:
- issues read addresses to the X and Y sample memories;
- drives enable/clear to the MAC accumulator;
- commands the Z-memory write of each finished sum.

It is the initiator that feeds the MAC block and collects its result. It sits between the top-level configuration registers and the X/Y/Z memories.

## Interface
- DATA_WIDTH, 8, sample width; accumulator result is 2*DATA_WIDTH
- ADDR_WIDTH, 5, X/Y memory address width; sizes range 1..2^ADDR_WIDTH-1
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle request; sampled only in IDLE
- sizeX_i  in  ADDR_WIDTH  length of X; latched at start
- sizeY_i  in  ADDR_WIDTH  length of Y; latched at start
- memX_addr_o  out  ADDR_WIDTH  X read address (sync-read memory, 1-cycle latency)
- memY_addr_o  out  ADDR_WIDTH  Y read address (same latency)
- memZ_addr_o  out  ADDR_WIDTH+1  Z write address
- memZ_we_o  out  1  Z write strobe; Z memory data input is the MAC dataZ output
- mac_en_o  out  1  accumulate enable to MAC
- mac_clr_o  out  1  accumulator clear to MAC
- busy_o  out  1  high in INIT, READ, WAIT, WRITE
- done_o  out  1  one-cycle pulse at completion

## Operation
- Output index i runs 0..sizeX+sizeY-2.
- For each i: kmin = max(0, i-(sizeY-1)), kmax = min(i, sizeX-1), n = kmax-kmin+1 ≥ 1.
- Products are x[k]*y[i-k] for k = kmin..kmax.
- Width rules:
  - i, kmin, kmax are ADDR_WIDTH+1 bits.
  - The Y address i-k always fits in ADDR_WIDTH.
  - Accumulator overflow wraps modulo 2^(2*DATA_WIDTH) inside the MAC; no saturation here.
- States:
  - IDLE: all outputs 0. start_i=1 → latch sizes. If either size is 0 → DONE; else → INIT.
  - INIT: mac_clr_o=1; i=0; compute bounds → READ.
  - READ: drive memX_addr=k, memY_addr=i-k; k increments each cycle from kmin. After issuing k=kmax → WAIT.
  - WAIT: one cycle; no new addresses → WRITE.
  - WRITE: memZ_we_o=1, memZ_addr_o=i, mac_clr_o=1. If i = sizeX+sizeY-2 → DONE; else i++, load new bounds → READ.
  - DONE: done_o=1 for one cycle → IDLE.
- mac_en_o is a one-cycle-delayed copy of "READ issued an address". It is therefore high in READ cycles 2..n and in WAIT, aligned with memory read data.
- mac_en_o and mac_clr_o are never asserted in the same cycle.
- start_i outside IDLE is ignored; sizeX_i/sizeY_i changes after start have no effect.
- rst at any time → IDLE immediately, all outputs 0. A partial Z result is not written.

## Timing
- All outputs are registered or decoded from registered state; reset value of every output is 0.
- Per output index: n READ cycles + WAIT + WRITE = n+2 cycles.
- Z write in WRITE samples the MAC output, which holds all n products at that cycle. The clear takes effect at the same edge.
- Total, start edge to done_o: 1 (INIT) + sizeX*sizeY + 2*(sizeX+sizeY-1) cycles, then done_o for 1 cycle.
- Zero-size start: done_o asserted 1 cycle after start, with no writes.
- Back-to-back run: start_i is accepted the cycle after DONE, i.e. in IDLE.

## Structure
- Package conv_pkg:
  - state enum typedef (IDLE, INIT, READ, WAIT, WRITE, DONE);
  - derived widths IDX_WIDTH = ADDR_WIDTH+1.
- Sub-module conv_kbounds: combinational; takes i, sizeX, sizeY and gives kmin, kmax, last_idx flag. Reused by bench model.
- Remainder is one FSM plus the i/k counters and the en delay flop.

## Test plan
- Basic run, sizeX=3, sizeY=2, X=[1,2,3], Y=[4,5] → Z writes at addrs 0..3 = [4,13,22,15]; done_o 16 cycles after start.
- Minimal run, sizeX=1, sizeY=1, X=[7], Y=[9] → single write Z[0]=63; done_o 5 cycles after start.
- Maximum size, sizeX=sizeY=31, all samples 255 → 61 writes:
  - Z[i] = n*65025 mod 2^16;
  - address ranges never exceed 30;
  - check mac_en/mac_clr never coincide.
- Zero size, sizeX=0 → done_o next cycle; no memZ_we_o, mac_en_o or busy_o pulse.
- Start while busy → second pulse ignored; write count and results unchanged.
- Reset mid-run, rst asserted during READ of i=2 → all outputs 0 next cycle. A later start gives correct results.
